// File: rtl/slot_mem_seq_pkg.sv
// Shared definitions for the slot memory sequencer: widths, defaults and FSM state type.
package slot_mem_seq_pkg;

    localparam int unsigned DEF_ADDR_W  = 27;
    localparam int unsigned DEF_TIMEOUT = 255;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned SRAM_AW     = 18;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SD_REQ  = 3'd1,
        ST_SD_WAIT = 3'd2,
        ST_SR_RD   = 3'd3,
        ST_SR_WR   = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/slot_mem_seq.sv
// Slot memory sequencer: turns a CPU memory cycle into an SDRAM request/ack
// handshake or a backup-SRAM BRAM access, with an SDRAM ack timeout.
module slot_mem_seq
    import slot_mem_seq_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_rnw,
    input  logic                ram_cs,
    input  logic                sram_cs,
    input  logic                cpu_req,
    input  logic [DATA_W-1:0]   cpu_wdata,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                cpu_wait,
    output logic [ADDR_W-1:0]   sdram_addr,
    output logic [DATA_W-1:0]   sdram_din,
    output logic                sdram_we,
    output logic                sdram_req,
    input  logic                sdram_ack,
    input  logic [DATA_W-1:0]   sdram_dout,
    output logic [SRAM_AW-1:0]  sram_addr,
    output logic [DATA_W-1:0]   sram_din,
    output logic                sram_we,
    input  logic [DATA_W-1:0]   sram_dout,
    output logic                timeout_err
);

    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt, cnt_inc;
    logic                rnw_q, rnw_nxt;
    logic [DATA_W-1:0]   rdata_nxt, sd_din_nxt, sr_din_nxt;
    logic [ADDR_W-1:0]   sd_addr_nxt;
    logic                sd_req_nxt, sd_we_nxt, sr_we_nxt, to_nxt;

    // The BRAM is addressed straight from the mapper so read data lands in SR_RD.
    assign sram_addr = mem_addr[SRAM_AW-1:0];

    // Wait is visible in the request cycle itself, before the FSM leaves IDLE.
    assign cpu_wait = (cpu_req & (ram_cs | sram_cs) & (state == ST_IDLE))
                    | ((state != ST_IDLE) & (state != ST_DONE));

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        cnt_inc     = cnt + CNT_W'(1);
        rnw_nxt     = rnw_q;
        rdata_nxt   = cpu_rdata;
        sd_req_nxt  = sdram_req;
        sd_we_nxt   = sdram_we;
        sd_addr_nxt = sdram_addr;
        sd_din_nxt  = sdram_din;
        sr_din_nxt  = sram_din;
        sr_we_nxt   = 1'b0;
        to_nxt      = 1'b0;

        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (cpu_req) begin
                    if (sram_cs) begin
                        sr_din_nxt = cpu_wdata;
                        if (mem_rnw) begin
                            state_nxt = ST_SR_RD;
                        end else begin
                            state_nxt = ST_SR_WR;
                            sr_we_nxt = 1'b1;
                        end
                    end else if (ram_cs) begin
                        state_nxt   = ST_SD_REQ;
                        sd_req_nxt  = 1'b1;
                        sd_we_nxt   = ~mem_rnw;
                        sd_addr_nxt = mem_addr;
                        sd_din_nxt  = cpu_wdata;
                        rnw_nxt     = mem_rnw;
                    end else begin
                        rdata_nxt = 8'hFF;
                    end
                end
            end
            ST_SD_REQ: begin
                state_nxt = ST_SD_WAIT;
            end
            ST_SD_WAIT: begin
                // An ack in the final counted cycle still wins over the abort.
                if (sdram_ack) begin
                    if (rnw_q) rdata_nxt = sdram_dout;
                    sd_req_nxt = 1'b0;
                    sd_we_nxt  = 1'b0;
                    state_nxt  = ST_DONE;
                end else if (cnt_inc == TO_CNT) begin
                    if (rnw_q) rdata_nxt = 8'hFF;
                    to_nxt     = 1'b1;
                    sd_req_nxt = 1'b0;
                    sd_we_nxt  = 1'b0;
                    cnt_nxt    = cnt_inc;
                    state_nxt  = ST_DONE;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            ST_SR_RD: begin
                rdata_nxt = sram_dout;
                state_nxt = ST_DONE;
            end
            ST_SR_WR: begin
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            rnw_q       <= 1'b1;
            cpu_rdata   <= 8'hFF;
            sdram_req   <= 1'b0;
            sdram_we    <= 1'b0;
            sdram_addr  <= '0;
            sdram_din   <= '0;
            sram_din    <= '0;
            sram_we     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            rnw_q       <= rnw_nxt;
            cpu_rdata   <= rdata_nxt;
            sdram_req   <= sd_req_nxt;
            sdram_we    <= sd_we_nxt;
            sdram_addr  <= sd_addr_nxt;
            sdram_din   <= sd_din_nxt;
            sram_din    <= sr_din_nxt;
            sram_we     <= sr_we_nxt;
            timeout_err <= to_nxt;
        end
    end

endmodule
